// File: rtl/kbd_display_ctrl.sv
// PS/2 keyboard front end: make/break decoding, modifier tracking, ASCII
// adjustment, a BCD press counter and seven-segment (active-low gfedcba) drive.
//
// Parameters:
//   CNT_DIGITS       number of BCD digits in the press counter (1..4)
//   BLANK_ON_RELEASE 1: HEX0..HEX3 blank while no key is held; 0: hold last
//
// Ports:
//   clk        single clock, all state on the rising edge
//   clrn       synchronous active-low reset
//   scan_valid one-cycle strobe for a received PS/2 byte
//   scan_code  received byte
//   ascii_in   unshifted ASCII for scan_code from an external ROM
//   ascii_out  registered, modifier-adjusted ASCII of the held key
//   shift      either Shift key held
//   capslock   Caps Lock toggle state
//   key_held   a non-modifier key is currently down
//   HEX0/HEX1  scan code low/high nibble glyphs
//   HEX2/HEX3  ascii_out low/high nibble glyphs
//   hex_cnt    press counter glyphs, digit 0 in bits [6:0]
//
// Build option: define KBD_DISP_LZ_BLANK_EN to blank leading zero digits of
// the press counter (digit 0 is always shown).

module kbd_display_ctrl #(
    parameter int CNT_DIGITS       = 2,
    parameter int BLANK_ON_RELEASE = 1
) (
    input  logic                      clk,
    input  logic                      clrn,
    input  logic                      scan_valid,
    input  logic [7:0]                scan_code,
    input  logic [7:0]                ascii_in,
    output logic [7:0]                ascii_out,
    output logic                      shift,
    output logic                      capslock,
    output logic                      key_held,
    output logic [6:0]                HEX0,
    output logic [6:0]                HEX1,
    output logic [6:0]                HEX2,
    output logic [6:0]                HEX3,
    output logic [7*CNT_DIGITS-1:0]   hex_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0] CODE_BRK  = 8'hF0;
    localparam logic [7:0] CODE_EXT  = 8'hE0;
    localparam logic [7:0] CODE_LSH  = 8'h12;
    localparam logic [7:0] CODE_RSH  = 8'h59;
    localparam logic [7:0] CODE_CAPS = 8'h58;
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    state_t state, state_nxt;

    logic [7:0]              held_code;
    logic                    shift_l, shift_r;
    logic                    caps_held;
    logic [4*CNT_DIGITS-1:0] cnt, cnt_nxt;

    // Decoded events for the current byte
    logic is_make, is_brk, ext_ctx;
    logic is_lsh, is_rsh, is_caps, is_mod;
    logic new_key, rel_key;
    logic [7:0] ascii_adj;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Shift/Caps adjustment of the unshifted ROM character
    function automatic logic [7:0] adj_ascii(
        input logic [7:0] a,
        input logic       sh,
        input logic       cl
    );
        logic [7:0] r;
        r = a;
        if (a >= 8'h61 && a <= 8'h7A) begin
            if (sh ^ cl) r = a - 8'h20;
        end else if (sh) begin
            case (a)
                "0":  r = ")";
                "1":  r = "!";
                "2":  r = "@";
                "3":  r = "#";
                "4":  r = "$";
                "5":  r = "%";
                "6":  r = "^";
                "7":  r = "&";
                "8":  r = "*";
                "9":  r = "(";
                "-":  r = "_";
                "=":  r = "+";
                8'h60: r = "~";
                "[":  r = "{";
                "]":  r = "}";
                8'h5C: r = "|";
                ";":  r = ":";
                8'h27: r = 8'h22;
                ",":  r = "<";
                ".":  r = ">";
                "/":  r = "?";
                default: r = a;
            endcase
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        is_make   = 1'b0;
        is_brk    = 1'b0;
        ext_ctx   = (state == EXT) || (state == EXT_BRK);
        if (scan_valid) begin
            unique case (state)
                IDLE: begin
                    if (scan_code == CODE_BRK)      state_nxt = BRK;
                    else if (scan_code == CODE_EXT) state_nxt = EXT;
                    else                            is_make   = 1'b1;
                end
                EXT: begin
                    if (scan_code == CODE_BRK) begin
                        state_nxt = EXT_BRK;
                    end else begin
                        state_nxt = IDLE;
                        is_make   = 1'b1;
                    end
                end
                BRK, EXT_BRK: begin
                    state_nxt = IDLE;
                    is_brk    = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Modifiers are only recognised without the E0 prefix
        is_lsh  = !ext_ctx && (scan_code == CODE_LSH);
        is_rsh  = !ext_ctx && (scan_code == CODE_RSH);
        is_caps = !ext_ctx && (scan_code == CODE_CAPS);
        is_mod  = is_lsh || is_rsh || is_caps;

        new_key = is_make && !is_mod && (scan_code != held_code);
        rel_key = is_brk && !is_mod && (scan_code == held_code);

        ascii_adj = ext_ctx ? 8'h00 : adj_ascii(ascii_in, shift, capslock);
    end

    // BCD increment; all-9s rolls over to all-0s
    always_comb begin
        logic carry;
        logic [3:0] d;
        cnt_nxt = cnt;
        carry   = 1'b1;
        for (int i = 0; i < CNT_DIGITS; i++) begin
            d = cnt[4*i +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    cnt_nxt[4*i +: 4] = 4'd0;
                end else begin
                    cnt_nxt[4*i +: 4] = d + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            held_code <= 8'h00;
            key_held  <= 1'b0;
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            capslock  <= 1'b0;
            caps_held <= 1'b0;
            ascii_out <= 8'h00;
            cnt       <= '0;
        end else begin
            if (is_make && is_lsh) shift_l <= 1'b1;
            if (is_brk  && is_lsh) shift_l <= 1'b0;
            if (is_make && is_rsh) shift_r <= 1'b1;
            if (is_brk  && is_rsh) shift_r <= 1'b0;

            // Typematic repeats of Caps Lock arrive while it is held
            if (is_make && is_caps) begin
                caps_held <= 1'b1;
                if (!caps_held) capslock <= ~capslock;
            end
            if (is_brk && is_caps) caps_held <= 1'b0;

            if (new_key) begin
                held_code <= scan_code;
                key_held  <= 1'b1;
                ascii_out <= ascii_adj;
                cnt       <= cnt_nxt;
            end else if (rel_key) begin
                key_held  <= 1'b0;
            end
        end
    end

    assign shift = shift_l | shift_r;

    logic blank;
    assign blank = (BLANK_ON_RELEASE != 0) && !key_held;

    assign HEX0 = blank ? SEG_OFF : seg7(held_code[3:0]);
    assign HEX1 = blank ? SEG_OFF : seg7(held_code[7:4]);
    assign HEX2 = blank ? SEG_OFF : seg7(ascii_out[3:0]);
    assign HEX3 = blank ? SEG_OFF : seg7(ascii_out[7:4]);

    always_comb begin
        logic [3:0] d;
`ifdef KBD_DISP_LZ_BLANK_EN
        logic seen;
        seen = 1'b0;
`endif
        hex_cnt = '0;
        for (int i = CNT_DIGITS - 1; i >= 0; i--) begin
            d = cnt[4*i +: 4];
`ifdef KBD_DISP_LZ_BLANK_EN
            if (d != 4'd0 || i == 0) seen = 1'b1;
            hex_cnt[7*i +: 7] = seen ? seg7(d) : SEG_OFF;
`else
            hex_cnt[7*i +: 7] = seg7(d);
`endif
        end
    end

endmodule

// File: tb/tb_kbd_display_ctrl.sv
// Directed bench for kbd_display_ctrl (CNT_DIGITS=2, BLANK_ON_RELEASE=1).
// Models the ASCII ROM for the few scan codes used.

module tb_kbd_display_ctrl;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        scan_valid = 1'b0;
    logic [7:0]  scan_code = 8'h00;
    logic [7:0]  ascii_in;
    logic [7:0]  ascii_out;
    logic        shift, capslock, key_held;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;
    logic [13:0] hex_cnt;

    int vecs = 0;
    int errs = 0;

    kbd_display_ctrl #(.CNT_DIGITS(2), .BLANK_ON_RELEASE(1)) dut (
        .clk(clk), .clrn(clrn), .scan_valid(scan_valid),
        .scan_code(scan_code), .ascii_in(ascii_in),
        .ascii_out(ascii_out), .shift(shift), .capslock(capslock),
        .key_held(key_held), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
        .HEX3(HEX3), .hex_cnt(hex_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [7:0] c);
        case (c)
            8'h1C: return 8'h61;
            8'h32: return 8'h62;
            8'h16: return 8'h31;
            8'h75: return 8'h38;
            default: return 8'h00;
        endcase
    endfunction

    always_comb ascii_in = rom(scan_code);

    function automatic logic [6:0] seg(input int n);
        case (n)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            12: return 7'b1000110;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    function automatic logic [13:0] exp_cnt(input int n);
        logic [6:0] hi;
        hi = seg(n / 10);
`ifdef KBD_DISP_LZ_BLANK_EN
        if (n / 10 == 0) hi = 7'h7F;
`endif
        return {hi, seg(n % 10)};
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scan_valid = 1'b1;
        scan_code  = b;
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vecs++; if (key_held !== 1'b0) begin errs++; $display("FAIL rst key_held got %b want 0", key_held); end
        vecs++; if (ascii_out !== 8'h00) begin errs++; $display("FAIL rst ascii got %h want 00", ascii_out); end
        vecs++; if (shift !== 1'b0 || capslock !== 1'b0) begin errs++; $display("FAIL rst mods got %b%b want 00", shift, capslock); end
        vecs++; if ({HEX3, HEX2, HEX1, HEX0} !== {4{7'h7F}}) begin errs++; $display("FAIL rst hex got %h want blank", {HEX3, HEX2, HEX1, HEX0}); end
        vecs++; if (hex_cnt !== exp_cnt(0)) begin errs++; $display("FAIL rst cnt got %h want %h", hex_cnt, exp_cnt(0)); end
    endtask

    task automatic test_basic();
        do_reset();
        send(8'h1C);
        vecs++; if (key_held !== 1'b1) begin errs++; $display("FAIL basic held got %b want 1", key_held); end
        vecs++; if (ascii_out !== 8'h61) begin errs++; $display("FAIL basic ascii got %h want 61", ascii_out); end
        vecs++; if (HEX1 !== seg(1) || HEX0 !== seg(12)) begin errs++; $display("FAIL basic code hex got %b %b want 1C", HEX1, HEX0); end
        vecs++; if (HEX3 !== seg(6) || HEX2 !== seg(1)) begin errs++; $display("FAIL basic ascii hex got %b %b want 61", HEX3, HEX2); end
        send(8'h1C);
        send(8'h1C);
        vecs++; if (hex_cnt !== exp_cnt(1)) begin errs++; $display("FAIL basic repeat cnt got %h want %h", hex_cnt, exp_cnt(1)); end
        send(8'hF0);
        vecs++; if (key_held !== 1'b1) begin errs++; $display("FAIL basic mid-break held got %b want 1", key_held); end
        send(8'h1C);
        vecs++; if (key_held !== 1'b0) begin errs++; $display("FAIL basic break held got %b want 0", key_held); end
        vecs++; if ({HEX3, HEX2, HEX1, HEX0} !== {4{7'h7F}}) begin errs++; $display("FAIL basic blank got %h want blank", {HEX3, HEX2, HEX1, HEX0}); end
        vecs++; if (hex_cnt !== exp_cnt(1)) begin errs++; $display("FAIL basic cnt got %h want %h", hex_cnt, exp_cnt(1)); end
    endtask

    task automatic test_shift();
        do_reset();
        send(8'h12);
        vecs++; if (shift !== 1'b1 || key_held !== 1'b0) begin errs++; $display("FAIL shift make got sh=%b held=%b want 1 0", shift, key_held); end
        send(8'h16);
        vecs++; if (shift !== 1'b1) begin errs++; $display("FAIL shift during got %b want 1", shift); end
        vecs++; if (ascii_out !== 8'h21) begin errs++; $display("FAIL shift ascii got %h want 21", ascii_out); end
        send(8'hF0); send(8'h16);
        send(8'hF0); send(8'h12);
        vecs++; if (shift !== 1'b0) begin errs++; $display("FAIL shift release got %b want 0", shift); end
        vecs++; if (hex_cnt !== exp_cnt(1)) begin errs++; $display("FAIL shift cnt got %h want %h", hex_cnt, exp_cnt(1)); end
        send(8'h59);
        vecs++; if (shift !== 1'b1) begin errs++; $display("FAIL rshift make got %b want 1", shift); end
        send(8'hF0); send(8'h59);
        vecs++; if (shift !== 1'b0) begin errs++; $display("FAIL rshift break got %b want 0", shift); end
    endtask

    task automatic test_caps();
        do_reset();
        send(8'h58);
        vecs++; if (capslock !== 1'b1) begin errs++; $display("FAIL caps on got %b want 1", capslock); end
        send(8'h58);
        vecs++; if (capslock !== 1'b1) begin errs++; $display("FAIL caps repeat got %b want 1", capslock); end
        send(8'hF0); send(8'h58);
        send(8'h1C);
        vecs++; if (ascii_out !== 8'h41) begin errs++; $display("FAIL caps ascii got %h want 41", ascii_out); end
        send(8'hF0); send(8'h1C);
        send(8'h12);
        send(8'h32);
        vecs++; if (ascii_out !== 8'h62) begin errs++; $display("FAIL caps+shift ascii got %h want 62", ascii_out); end
        send(8'hF0); send(8'h32);
        send(8'hF0); send(8'h12);
        send(8'h58);
        vecs++; if (capslock !== 1'b0) begin errs++; $display("FAIL caps off got %b want 0", capslock); end
        vecs++; if (hex_cnt !== exp_cnt(2)) begin errs++; $display("FAIL caps cnt got %h want %h", hex_cnt, exp_cnt(2)); end
    endtask

    task automatic test_wrap();
        logic [7:0] c;
        int n;
        do_reset();
        c = 8'h01;
        n = 0;
        while (n < 100) begin
            if (c != 8'h12 && c != 8'h58 && c != 8'h59) begin
                send(c);
                n++;
                if (n == 7) begin
                    vecs++; if (hex_cnt !== exp_cnt(7)) begin errs++; $display("FAIL wrap cnt7 got %h want %h", hex_cnt, exp_cnt(7)); end
                end
                if (n == 10) begin
                    vecs++; if (hex_cnt !== exp_cnt(10)) begin errs++; $display("FAIL wrap cnt10 got %h want %h", hex_cnt, exp_cnt(10)); end
                end
                if (n == 99) begin
                    vecs++; if (hex_cnt !== exp_cnt(99)) begin errs++; $display("FAIL wrap cnt99 got %h want %h", hex_cnt, exp_cnt(99)); end
                end
                if (n == 100) begin
                    vecs++; if (hex_cnt !== exp_cnt(0)) begin errs++; $display("FAIL wrap cnt00 got %h want %h", hex_cnt, exp_cnt(0)); end
                end
                send(8'hF0);
                send(c);
            end
            c = c + 8'h01;
        end
    endtask

    task automatic test_ext_reset();
        do_reset();
        send(8'hE0);
        send(8'h75);
        vecs++; if (key_held !== 1'b1 || ascii_out !== 8'h00) begin errs++; $display("FAIL ext make got held=%b ascii=%h want 1 00", key_held, ascii_out); end
        vecs++; if (HEX1 !== seg(7) || HEX0 !== seg(5)) begin errs++; $display("FAIL ext hex got %b %b want 75", HEX1, HEX0); end
        vecs++; if (hex_cnt !== exp_cnt(1)) begin errs++; $display("FAIL ext cnt got %h want %h", hex_cnt, exp_cnt(1)); end
        send(8'hF0);
        @(negedge clk);
        clrn       = 1'b0;
        scan_valid = 1'b1;
        scan_code  = 8'h1C;
        @(negedge clk);
        clrn       = 1'b1;
        scan_valid = 1'b0;
        vecs++; if (key_held !== 1'b0 || hex_cnt !== exp_cnt(0)) begin errs++; $display("FAIL ext rst got held=%b cnt=%h want 0 %h", key_held, hex_cnt, exp_cnt(0)); end
        send(8'h1C);
        vecs++; if (key_held !== 1'b1 || ascii_out !== 8'h61) begin errs++; $display("FAIL ext post make got held=%b ascii=%h want 1 61", key_held, ascii_out); end
        vecs++; if (hex_cnt !== exp_cnt(1)) begin errs++; $display("FAIL ext post cnt got %h want %h", hex_cnt, exp_cnt(1)); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(8'h1C);
        send(8'h32);
        send(8'hF0);
        send(8'h1C);
        vecs++; if (key_held !== 1'b1) begin errs++; $display("FAIL b2b held got %b want 1", key_held); end
        vecs++; if (HEX1 !== seg(3) || HEX0 !== seg(2)) begin errs++; $display("FAIL b2b code hex got %b %b want 32", HEX1, HEX0); end
        vecs++; if (ascii_out !== 8'h62) begin errs++; $display("FAIL b2b ascii got %h want 62", ascii_out); end
        vecs++; if (hex_cnt !== exp_cnt(2)) begin errs++; $display("FAIL b2b cnt got %h want %h", hex_cnt, exp_cnt(2)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift();
        test_caps();
        test_wrap();
        test_ext_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
